// File: rtl/csi2_pkg.sv
// Shared CSI-2 data-type codes, sequencer states and error-bit positions for the
// frame sequencer and its payload counter.
package csi2_pkg;

    localparam logic [5:0] CSI2_DT_FS       = 6'h00;
    localparam logic [5:0] CSI2_DT_FE       = 6'h01;
    localparam logic [5:0] CSI2_DT_LS       = 6'h02;
    localparam logic [5:0] CSI2_DT_LE       = 6'h03;
    localparam logic [5:0] CSI2_DT_LONG_MIN = 6'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IN_FRAME,
        ST_IN_LINE,
        ST_DROP
    } seq_state_t;

    localparam int ERR_FE_OUTSIDE   = 0;
    localparam int ERR_FS_INSIDE    = 1;
    localparam int ERR_LONG_OUTSIDE = 2;
    localparam int ERR_LENGTH       = 3;

endpackage

// File: rtl/csi2_payload_counter.sv
// Counts payload bytes of the current long packet, builds the per-beat byte mask and,
// when CSI2_LENGTH_CHECK_EN is defined, compares delivered bytes against the header count.
module csi2_payload_counter
    import csi2_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_count,
    input  logic        beat,
    output logic        beat_accept,
    output logic [3:0]  beat_keep,
    output logic        length_error
);

    logic [15:0] word_count_q, word_count_d;
    logic [15:0] byte_count_q, byte_count_d;
    logic [15:0] remaining;
    logic [15:0] beat_bytes;

    // NOTE: every variable gets a value before any branch so no latch is inferred.
    always_comb begin
        remaining   = word_count_q - byte_count_q;
        beat_accept = beat && (remaining != 16'd0);
        beat_bytes  = 16'd4;
        beat_keep   = 4'hF;
        if (remaining < 16'd4) begin
            beat_bytes = remaining;
            beat_keep  = (4'b0001 << remaining[1:0]) - 4'd1;
        end

        word_count_d = load ? load_count : word_count_q;
        byte_count_d = byte_count_q;
        if (load) begin
            byte_count_d = 16'd0;
        end else if (beat_accept) begin
            byte_count_d = byte_count_q + beat_bytes;
        end
    end

`ifdef CSI2_LENGTH_CHECK_EN
    // The beat arriving alongside packet_done still belongs to the packet being closed.
    assign length_error = (byte_count_q + (beat_accept ? beat_bytes : 16'd0)) != word_count_q;
`else
    assign length_error = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_count_q <= '0;
            byte_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
            byte_count_q <= byte_count_d;
        end
    end

endmodule

// File: rtl/csi2_frame_sequencer.sv
// Tracks FS/FE/long packets on one virtual channel and turns accepted payload into a
// framed pixel stream with counters and sticky error flags (optional CSI2_LENGTH_CHECK_EN).
module csi2_frame_sequencer
    import csi2_pkg::*;
#(
    parameter logic [1:0]  VIRTUAL_CHANNEL = 2'd0,
    parameter int unsigned MAX_LINES       = 4095
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            header_valid,
    input  logic [1:0]      virtual_channel,
    input  logic [5:0]      image_data_type,
    input  logic [15:0]     word_count,
    input  logic [3:0][7:0] image_data,
    input  logic            image_data_enable,
    input  logic            packet_done,
    input  logic            error_clear,
    output logic            frame_valid,
    output logic            line_valid,
    output logic [3:0][7:0] pixel_data,
    output logic [3:0]      pixel_keep,
    output logic            pixel_valid,
    output logic [15:0]     frame_number,
    output logic [11:0]     line_count,
    output logic            error_pulse,
    output logic [3:0]      error_status
);

    seq_state_t      state_q, state_d, mid_state;
    logic            frame_valid_q, frame_valid_d;
    logic            line_valid_q, line_valid_d;
    logic [3:0][7:0] pixel_data_q, pixel_data_d;
    logic [3:0]      pixel_keep_q, pixel_keep_d;
    logic            pixel_valid_q, pixel_valid_d;
    logic [15:0]     frame_number_q, frame_number_d;
    logic [11:0]     line_count_q, line_count_d;
    logic            error_pulse_q, error_pulse_d;
    logic [3:0]      error_status_q, error_status_d;

    logic            hdr_ours, is_long, line_start, beat, beat_accept, length_error;
    logic [3:0]      beat_keep, err_new;

    assign beat = image_data_enable && (state_q == ST_IN_LINE);

    csi2_payload_counter u_payload_counter (
        .clock        (clock),
        .reset        (reset),
        .load         (line_start),
        .load_count   (word_count),
        .beat         (beat),
        .beat_accept  (beat_accept),
        .beat_keep    (beat_keep),
        .length_error (length_error)
    );

    always_comb begin
        hdr_ours       = header_valid && (virtual_channel == VIRTUAL_CHANNEL);
        is_long        = image_data_type >= CSI2_DT_LONG_MIN;
        mid_state      = state_q;
        frame_number_d = frame_number_q;
        line_count_d   = line_count_q;
        err_new        = '0;
        line_start     = 1'b0;

        // End of packet resolves first; a header in the same cycle sees the result.
        if (packet_done) begin
            if (state_q == ST_IN_LINE) begin
                mid_state = ST_IN_FRAME;
                if (line_count_q != 12'(MAX_LINES)) line_count_d = line_count_q + 12'd1;
                err_new[ERR_LENGTH] = length_error;
            end else if (state_q == ST_DROP) begin
                mid_state = ST_IDLE;
            end
        end

        state_d = mid_state;
        if (hdr_ours) begin
            case (mid_state)
                ST_IDLE: begin
                    if (image_data_type == CSI2_DT_FS) begin
                        state_d        = ST_IN_FRAME;
                        frame_number_d = word_count;
                        line_count_d   = '0;
                    end else if (image_data_type == CSI2_DT_FE) begin
                        err_new[ERR_FE_OUTSIDE] = 1'b1;
                    end else if (is_long) begin
                        err_new[ERR_LONG_OUTSIDE] = 1'b1;
                        state_d = ST_DROP;
                    end
                end
                ST_IN_FRAME: begin
                    if (is_long) begin
                        state_d    = ST_IN_LINE;
                        line_start = 1'b1;
                    end else if (image_data_type == CSI2_DT_FE) begin
                        state_d = ST_IDLE;
                    end else if (image_data_type == CSI2_DT_FS) begin
                        err_new[ERR_FS_INSIDE] = 1'b1;
                        frame_number_d = word_count;
                        line_count_d   = '0;
                    end
                end
                default: ;
            endcase
        end

        frame_valid_d  = (state_d == ST_IN_FRAME) || (state_d == ST_IN_LINE);
        line_valid_d   = (state_d == ST_IN_LINE);
        pixel_valid_d  = beat_accept;
        pixel_data_d   = beat_accept ? image_data : '0;
        pixel_keep_d   = beat_accept ? beat_keep : '0;
        error_pulse_d  = |err_new;
        // A fresh error wins over a simultaneous clear.
        error_status_d = (error_clear ? 4'b0000 : error_status_q) | err_new;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            frame_valid_q  <= 1'b0;
            line_valid_q   <= 1'b0;
            pixel_data_q   <= '0;
            pixel_keep_q   <= '0;
            pixel_valid_q  <= 1'b0;
            frame_number_q <= '0;
            line_count_q   <= '0;
            error_pulse_q  <= 1'b0;
            error_status_q <= '0;
        end else begin
            state_q        <= state_d;
            frame_valid_q  <= frame_valid_d;
            line_valid_q   <= line_valid_d;
            pixel_data_q   <= pixel_data_d;
            pixel_keep_q   <= pixel_keep_d;
            pixel_valid_q  <= pixel_valid_d;
            frame_number_q <= frame_number_d;
            line_count_q   <= line_count_d;
            error_pulse_q  <= error_pulse_d;
            error_status_q <= error_status_d;
        end
    end

    assign frame_valid  = frame_valid_q;
    assign line_valid   = line_valid_q;
    assign pixel_data   = pixel_data_q;
    assign pixel_keep   = pixel_keep_q;
    assign pixel_valid  = pixel_valid_q;
    assign frame_number = frame_number_q;
    assign line_count   = line_count_q;
    assign error_pulse  = error_pulse_q;
    assign error_status = error_status_q;

endmodule

// File: tb/tb_csi2_frame_sequencer.sv
// Scoreboard bench for csi2_frame_sequencer: a packet-level reference model predicts pixel
// beats and error events; a negedge monitor pops and compares whatever the DUT emits.
module tb_csi2_frame_sequencer;

    localparam int TB_MAX_LINES = 6;

    logic            clock = 1'b0;
    logic            reset;
    logic            header_valid;
    logic [1:0]      virtual_channel;
    logic [5:0]      image_data_type;
    logic [15:0]     word_count;
    logic [3:0][7:0] image_data;
    logic            image_data_enable;
    logic            packet_done;
    logic            error_clear;
    logic            frame_valid, line_valid, pixel_valid, error_pulse;
    logic [3:0][7:0] pixel_data;
    logic [3:0]      pixel_keep, error_status;
    logic [15:0]     frame_number;
    logic [11:0]     line_count;

    csi2_frame_sequencer #(
        .VIRTUAL_CHANNEL (2'd0),
        .MAX_LINES       (TB_MAX_LINES)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .header_valid      (header_valid),
        .virtual_channel   (virtual_channel),
        .image_data_type   (image_data_type),
        .word_count        (word_count),
        .image_data        (image_data),
        .image_data_enable (image_data_enable),
        .packet_done       (packet_done),
        .error_clear       (error_clear),
        .frame_valid       (frame_valid),
        .line_valid        (line_valid),
        .pixel_data        (pixel_data),
        .pixel_keep        (pixel_keep),
        .pixel_valid       (pixel_valid),
        .frame_number      (frame_number),
        .line_count        (line_count),
        .error_pulse       (error_pulse),
        .error_status      (error_status)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } pix_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    pix_t       pix_q[$];
    logic [3:0] err_q[$];

    // Reference model state: packet-level view of the sequencer.
    bit         m_in_frame   = 1'b0;
    logic [15:0] m_frame_number = '0;
    int         m_line_count = 0;
    logic [3:0] m_err        = '0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        header_valid      = 1'b0;
        virtual_channel   = 2'd0;
        image_data_type   = 6'h00;
        word_count        = 16'h0000;
        image_data        = '0;
        image_data_enable = 1'b0;
        packet_done       = 1'b0;
        error_clear       = 1'b0;
    endtask

    task automatic model_error(input int bit_idx);
        m_err[bit_idx] = 1'b1;
        err_q.push_back(m_err);
    endtask

    task automatic model_short(input logic [5:0] dt, input logic [15:0] wc);
        if (dt == 6'h00) begin
            if (m_in_frame) model_error(1);
            m_in_frame     = 1'b1;
            m_frame_number = wc;
            m_line_count   = 0;
        end else if (dt == 6'h01) begin
            if (m_in_frame) m_in_frame = 1'b0;
            else model_error(0);
        end
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_frame_valid"},  frame_valid,  m_in_frame);
        check({tag, "_line_valid"},   line_valid,   0);
        check({tag, "_line_count"},   line_count,   m_line_count);
        check({tag, "_frame_number"}, frame_number, m_frame_number);
        check({tag, "_error_status"}, error_status, m_err);
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_frame_valid"},  frame_valid,  0);
        check({tag, "_line_valid"},   line_valid,   0);
        check({tag, "_pixel_valid"},  pixel_valid,  0);
        check({tag, "_pixel_data"},   pixel_data,   0);
        check({tag, "_pixel_keep"},   pixel_keep,   0);
        check({tag, "_frame_number"}, frame_number, 0);
        check({tag, "_line_count"},   line_count,   0);
        check({tag, "_error_pulse"},  error_pulse,  0);
        check({tag, "_error_status"}, error_status, 0);
    endtask

    task automatic send_short(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                              input bit clr);
        if (clr) m_err = '0;
        if (vc == 2'd0) model_short(dt, wc);
        header_valid    = 1'b1;
        virtual_channel = vc;
        image_data_type = dt;
        word_count      = wc;
        error_clear     = clr;
        tick();
        idle_inputs();
        check("frame_valid_after_header", frame_valid, m_in_frame);
        packet_done = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic drive_done(input bit fe_with_done);
        packet_done = 1'b1;
        if (fe_with_done) begin
            header_valid    = 1'b1;
            virtual_channel = 2'd0;
            image_data_type = 6'h01;
            word_count      = 16'h0000;
        end
    endtask

    task automatic send_long(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                             input int nbeats, input bit done_with_last, input bit fe_with_done);
        logic [31:0] beats[$];
        bit   accepted;
        bit   fv_exp;
        int   rem;
        int   delivered;
        pix_t p;
        for (int b = 0; b < nbeats; b++) beats.push_back($urandom);
        accepted  = (vc == 2'd0) && m_in_frame;
        fv_exp    = m_in_frame;
        delivered = 0;
        if ((vc == 2'd0) && !m_in_frame) model_error(2);
        if (accepted) begin
            for (int b = 0; b < nbeats; b++) begin
                rem = int'(wc) - 4 * b;
                if (rem > 0) begin
                    p.data = beats[b];
                    p.keep = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
                    pix_q.push_back(p);
                    delivered += (rem >= 4) ? 4 : rem;
                end
            end
            if (m_line_count < TB_MAX_LINES) m_line_count++;
`ifdef CSI2_LENGTH_CHECK_EN
            if (delivered != int'(wc)) model_error(3);
`endif
        end
        if (fe_with_done) model_short(6'h01, 16'h0000);

        header_valid    = 1'b1;
        virtual_channel = vc;
        image_data_type = dt;
        word_count      = wc;
        tick();
        idle_inputs();
        check("line_valid_after_header", line_valid, accepted);
        check("frame_valid_in_packet", frame_valid, fv_exp);
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) tick();
            image_data_enable = 1'b1;
            image_data        = beats[b];
            if (done_with_last && (b == nbeats - 1)) drive_done(fe_with_done);
            tick();
            idle_inputs();
        end
        if (!(done_with_last && (nbeats > 0))) begin
            drive_done(fe_with_done);
            tick();
            idle_inputs();
        end
    endtask

    task automatic clear_errors();
        error_clear = 1'b1;
        m_err       = '0;
        tick();
        idle_inputs();
        check("error_clear", error_status, 0);
    endtask

    // Monitor: pops expectations only when the DUT presents a beat or an error pulse.
    initial begin
        pix_t       ep;
        logic [3:0] ee;
        forever begin
            @(negedge clock);
            if (pixel_valid === 1'b1) begin
                if (pix_q.size() == 0) begin
                    check("pixel_unexpected", pixel_data, 0);
                    check("pixel_unexpected_valid", pixel_valid, 0);
                end else begin
                    ep = pix_q.pop_front();
                    check("pixel_data", pixel_data, ep.data);
                    check("pixel_keep", pixel_keep, ep.keep);
                end
            end
            if (error_pulse === 1'b1) begin
                if (err_q.size() == 0) begin
                    check("error_pulse_unexpected", error_pulse, 0);
                end else begin
                    ee = err_q.pop_front();
                    check("error_status_at_pulse", error_status, ee);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0;
        pix_t        p;
        int          kind;
        logic [15:0] wc;
        logic [1:0]  vc;

        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        outputs_zero("reset");

        // Basic frame: FS(7), 2-beat line of 8 bytes, FE.
        send_short(2'd0, 6'h00, 16'h0007, 1'b0);
        check("fs_frame_number", frame_number, 16'h0007);
        checkpoint("after_fs");
        send_long(2'd0, 6'h18, 16'd8, 2, 1'b0, 1'b0);
        check("line_count_one", line_count, 12'd1);
        checkpoint("after_line");
        send_short(2'd0, 6'h01, 16'h0000, 1'b0);
        check("frame_valid_after_fe", frame_valid, 0);
        checkpoint("after_fe");

        // Partial last beat with a third, surplus beat.
        send_short(2'd0, 6'h00, 16'h0010, 1'b0);
        send_long(2'd0, 6'h2A, 16'd6, 3, 1'b0, 1'b0);
        checkpoint("after_partial");
        send_short(2'd0, 6'h01, 16'h0000, 1'b0);

        // Protocol errors.
        send_short(2'd0, 6'h01, 16'h0000, 1'b0);
        check("fe_in_idle", error_status, 4'b0001);
        clear_errors();
        send_short(2'd0, 6'h00, 16'h0021, 1'b0);
        send_long(2'd0, 6'h1C, 16'd4, 1, 1'b1, 1'b0);
        send_short(2'd0, 6'h00, 16'h0022, 1'b0);
        check("fs_in_frame", error_status, 4'b0010);
        check("fs_restart_line_count", line_count, 12'd0);
        check("fs_restart_frame_number", frame_number, 16'h0022);
        send_short(2'd0, 6'h01, 16'h0000, 1'b0);
        clear_errors();
        send_long(2'd0, 6'h2B, 16'd8, 2, 1'b0, 1'b0);
        check("long_in_idle", error_status, 4'b0100);
        checkpoint("after_drop");
        clear_errors();

        // Virtual-channel filter.
        send_short(2'd1, 6'h00, 16'h0033, 1'b0);
        check("vc_filter_frame_valid", frame_valid, 0);
        check("vc_filter_error", error_status, 0);

        // Length check: 8-byte header, one beat only.
        send_short(2'd0, 6'h00, 16'h0044, 1'b0);
        send_long(2'd0, 6'h1E, 16'd8, 1, 1'b0, 1'b0);
`ifdef CSI2_LENGTH_CHECK_EN
        check("length_mismatch", error_status, 4'b1000);
`else
        check("length_mismatch", error_status, 4'b0000);
`endif
        send_short(2'd0, 6'h01, 16'h0000, 1'b0);
        clear_errors();

        // packet_done and FE header in the same cycle.
        send_short(2'd0, 6'h00, 16'h0050, 1'b0);
        send_long(2'd0, 6'h2C, 16'd8, 2, 1'b1, 1'b1);
        check("done_with_fe_frame_valid", frame_valid, 0);
        check("done_with_fe_line_count", line_count, 12'd1);
        checkpoint("after_done_fe");

        // error_clear with a new error in the same cycle.
        send_long(2'd0, 6'h30, 16'd4, 1, 1'b0, 1'b0);
        send_short(2'd0, 6'h01, 16'h0000, 1'b1);
        check("clear_vs_new_error", error_status, 4'b0001);
        clear_errors();

        // line_count saturation.
        send_short(2'd0, 6'h00, 16'h0060, 1'b0);
        repeat (8) send_long(2'd0, 6'h24, 16'd4, 1, 1'b0, 1'b0);
        check("line_count_saturates", line_count, TB_MAX_LINES);
        send_short(2'd0, 6'h01, 16'h0000, 1'b0);

        // Randomized packet soup.
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            vc   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            wc   = 16'($urandom_range(0, 20));
            case (kind)
                0, 1: send_short(vc, 6'h00, 16'($urandom), $urandom_range(0, 7) == 0);
                2:    send_short(vc, 6'h01, 16'h0000, $urandom_range(0, 7) == 0);
                3:    send_short(vc, 6'($urandom_range(2, 3)), 16'($urandom), 1'b0);
                4:    send_short(vc, 6'($urandom_range(4, 15)), 16'($urandom), 1'b0);
                default: send_long(vc, 6'($urandom_range(16, 63)), wc,
                                   $urandom_range(0, (int'(wc) + 3) / 4 + 1),
                                   $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            endcase
            checkpoint("rand");
        end

        // Reset in the middle of a line.
        send_short(2'd0, 6'h00, 16'h0042, 1'b0);
        header_valid    = 1'b1;
        image_data_type = 6'h20;
        word_count      = 16'd8;
        tick();
        idle_inputs();
        d0     = $urandom;
        p.data = d0;
        p.keep = 4'hF;
        pix_q.push_back(p);
        image_data_enable = 1'b1;
        image_data        = d0;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        outputs_zero("mid_reset");
        m_in_frame     = 1'b0;
        m_frame_number = '0;
        m_line_count   = 0;
        m_err          = '0;
        send_short(2'd0, 6'h00, 16'h0055, 1'b0);
        check("fs_after_reset", frame_number, 16'h0055);
        checkpoint("after_reset_fs");

        repeat (3) tick();
        check("pixel_queue_drained", pix_q.size(), 0);
        check("error_queue_drained", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
